// File: rtl/decode_hs_pkg.sv
// Shared decode types: control bundle, ALU/instruction-type enums, buffer states
// and the combinational control-unit and immediate decoders.
package riscv_structures;
   localparam int X0 = 0;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IT_R = 3'd0, IT_I = 3'd1, IT_S = 3'd2, IT_B = 3'd3,
      IT_U = 3'd4, IT_J = 3'd5, IT_BAD = 3'd6
   } instr_type_e;

   typedef enum logic [1:0] {
      SK_EMPTY = 2'd0, SK_ONE = 2'd1, SK_TWO = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic mem_write;
      logic mem_read;
      logic reg_write;
      logic use_imm;
      logic use_pc;
      logic is_jump;
   } de_ctrl_s;

   typedef struct packed {
      instr_type_e itype;
      alu_op_e     alu_op;
      de_ctrl_s    ctrl;
   } cu_out_s;

   // SUB only exists for register-register ops; bit 30 of an ADDI is immediate data
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic b30, input logic is_reg);
      case (f3)
         3'b000:  return (b30 && is_reg) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return b30 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic cu_out_s cu_decode(input logic [31:0] i);
      cu_out_s r;
      r.itype  = IT_BAD;
      r.alu_op = ALU_ADD;
      r.ctrl   = '0;
      case (i[6:0])
         7'b0110011: begin r.itype = IT_R; r.ctrl.reg_write = 1'b1; r.alu_op = alu_from_f3(i[14:12], i[30], 1'b1); end
         7'b0010011: begin r.itype = IT_I; r.ctrl.reg_write = 1'b1; r.ctrl.use_imm = 1'b1; r.alu_op = alu_from_f3(i[14:12], i[30], 1'b0); end
         7'b0000011: begin r.itype = IT_I; r.ctrl.reg_write = 1'b1; r.ctrl.use_imm = 1'b1; r.ctrl.mem_read = 1'b1; end
         7'b0100011: begin r.itype = IT_S; r.ctrl.mem_write = 1'b1; r.ctrl.use_imm = 1'b1; end
         7'b1100011: begin r.itype = IT_B; r.alu_op = ALU_SUB; end
         7'b0110111: begin r.itype = IT_U; r.ctrl.reg_write = 1'b1; r.ctrl.use_imm = 1'b1; r.alu_op = ALU_PASSB; end
         7'b0010111: begin r.itype = IT_U; r.ctrl.reg_write = 1'b1; r.ctrl.use_imm = 1'b1; r.ctrl.use_pc = 1'b1; end
         7'b1101111: begin r.itype = IT_J; r.ctrl.reg_write = 1'b1; r.ctrl.use_pc = 1'b1; r.ctrl.is_jump = 1'b1; end
         7'b1100111: begin r.itype = IT_I; r.ctrl.reg_write = 1'b1; r.ctrl.use_imm = 1'b1; r.ctrl.is_jump = 1'b1; end
         default:    r.itype = IT_BAD;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] imm_decode(input logic [31:0] i, input instr_type_e t);
      case (t)
         IT_I:    return {{21{i[31]}}, i[30:20]};
         IT_S:    return {{21{i[31]}}, i[30:25], i[11:7]};
         IT_B:    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
         IT_U:    return {i[31:12], 12'd0};
         IT_J:    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic rs1_used(input instr_type_e t);
      return (t == IT_R) || (t == IT_I) || (t == IT_S) || (t == IT_B);
   endfunction

   function automatic logic rs2_used(input instr_type_e t);
      return (t == IT_R) || (t == IT_S) || (t == IT_B);
   endfunction
endpackage

// File: rtl/decode_hs_skid.sv
// Two-entry valid/ready buffer: the main entry drives the consumer, the skid
// entry catches one push that arrives while the consumer is stalled.
module decode_skid
   import riscv_structures::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   output logic         full_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] data_o
);
   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d, skid_q, skid_d;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = SK_EMPTY;
      end else begin
         case (state_q)
            SK_EMPTY: begin
               if (push_i) begin state_d = SK_ONE; main_d = data_i; end
               else        state_d = SK_EMPTY;
            end
            SK_ONE: begin
               if (push_i && !out_ready_i) begin state_d = SK_TWO; skid_d = data_i; end
               else if (push_i)            main_d  = data_i;
               else if (out_ready_i)       state_d = SK_EMPTY;
               else                        state_d = SK_ONE;
            end
            // no push can arrive here: the producer sees full_o
            SK_TWO: begin
               if (out_ready_i) begin state_d = SK_ONE; main_d = skid_q; end
               else             state_d = SK_TWO;
            end
            default: state_d = SK_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= SK_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign data_o      = main_q;
   assign out_valid_o = (state_q != SK_EMPTY);
   assign full_o      = (state_q == SK_TWO);
endmodule

// File: rtl/decode_hs.sv
// Decode stage with fetch/execute valid-ready handshakes, load-use stall and
// write-back bypass into the source-register reads.
module decode_hs
   import riscv_structures::*;
#(
   parameter int  XLEN      = 32,
   parameter int  REG_COUNT = 32,
   parameter bit  WB_BYPASS = 1'b1,
   localparam int RA        = $clog2(REG_COUNT)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [RA-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_mem_read,
   input  logic [RA-1:0]   ex_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [RA-1:0]   out_rd,
   output logic [RA-1:0]   out_rs1,
   output logic [RA-1:0]   out_rs2,
   output logic [2:0]      out_funct3,
   output alu_op_e         out_alu_op,
   output de_ctrl_s        out_ctrl
);
   localparam int PW = 4*XLEN + 3*RA + 3 + $bits(alu_op_e) + $bits(de_ctrl_s);

   cu_out_s         cu_s;
   logic            use1_s, use2_s, hazard_s, skid_full_s, accept_s;
   logic [RA-1:0]   rs1_s, rs2_s, rd_s;
   logic [2:0]      funct3_s;
   logic [31:0]     imm32_s;
   logic [XLEN-1:0] imm_s, rs1_data_s, rs2_data_s;
   logic [XLEN-1:0] rf_q [REG_COUNT];
   logic [PW-1:0]   pl_in_s, pl_out_s;
   logic [3:0]      alu_bits_s;

   assign cu_s    = cu_decode(in_instr);
   assign use1_s  = rs1_used(cu_s.itype);
   assign use2_s  = rs2_used(cu_s.itype);
   // unused fields are presented as x0 so execute never sees stale register numbers
   assign rs1_s   = use1_s ? RA'(in_instr[19:15]) : RA'(X0);
   assign rs2_s   = use2_s ? RA'(in_instr[24:20]) : RA'(X0);
   assign rd_s    = cu_s.ctrl.reg_write ? RA'(in_instr[11:7]) : RA'(X0);
   assign funct3_s = ((cu_s.itype == IT_U) || (cu_s.itype == IT_J)) ? 3'd0 : in_instr[14:12];
   assign imm32_s = imm_decode(in_instr, cu_s.itype);
   assign imm_s   = XLEN'($signed(imm32_s));

   // register file write port; x0 stays hard-wired to zero
   always_ff @(posedge clk) begin
      if (wb_en && (wb_addr != RA'(X0))) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   assign rs1_data_s = (rs1_s == RA'(X0)) ? '0 :
                       (WB_BYPASS && wb_en && (wb_addr == rs1_s)) ? wb_data : rf_q[rs1_s];
   assign rs2_data_s = (rs2_s == RA'(X0)) ? '0 :
                       (WB_BYPASS && wb_en && (wb_addr == rs2_s)) ? wb_data : rf_q[rs2_s];

   assign hazard_s = ex_mem_read && (ex_rd != RA'(X0)) &&
                     ((use1_s && (ex_rd == rs1_s)) || (use2_s && (ex_rd == rs2_s)));
   assign in_ready = !reset && !skid_full_s && !hazard_s;
   assign accept_s = in_valid && in_ready && !flush;

   assign pl_in_s = {in_pc, rs1_data_s, rs2_data_s, imm_s, rd_s, rs1_s, rs2_s,
                     funct3_s, cu_s.alu_op, cu_s.ctrl};

   decode_skid #(.W(PW)) u_skid (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush),
      .push_i      (accept_s),
      .data_i      (pl_in_s),
      .full_o      (skid_full_s),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .data_o      (pl_out_s)
   );

   assign {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd, out_rs1, out_rs2,
           out_funct3, alu_bits_s, out_ctrl} = pl_out_s;
   assign out_alu_op = alu_op_e'(alu_bits_s);
endmodule
